sc_timer_general: RTL and testbench

Programmable countdown timer and speed-step generator that answers the game controller's timer and speed requests. It accepts a 4-bit tick count and a 4-bit speed threshold from the game state machine. It returns an active-low one-cycle expiry strobe and an active-low periodic speed strobe. The block sits between the game state machine and the free-running 50 MHz clock domain, and provides the timer_InLow and speedComparator_InLow inputs that the controller consumes.

---
 rtl/sc_timer_general.sv | 98 +++++++++
 tb/tb_sc_timer_general.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sc_timer_general.sv
// Countdown timer with periodic speed-step strobe for the game controller.
// Loads a tick count and a speed threshold, and emits active-low expiry and speed strobes.
module sc_timer_general #(
    parameter int unsigned PRESCALE_MAX   = 5000000,
    parameter int unsigned PRESCALE_WIDTH = 23
) (
    input  logic       SC_STATEMACHINE_GENERAL_CLOCK_50,
    input  logic       SC_STATEMACHINE_GENERAL_RESET_InHigh,
    input  logic       SC_TIMER_GENERAL_load_InLow,
    input  logic       SC_TIMER_GENERAL_clear_InLow,
    input  logic [3:0] SC_TIMER_GENERAL_timer_InBUS,
    input  logic [3:0] SC_TIMER_GENERAL_speed_InBUS,
    output logic       SC_TIMER_GENERAL_timer_OutLow,
    output logic       SC_TIMER_GENERAL_speedComparator_OutLow,
    output logic [3:0] SC_TIMER_GENERAL_count_OutBUS,
    output logic       SC_TIMER_GENERAL_busy_Out
);

    localparam int unsigned COUNT_WIDTH = 4;
    localparam logic [PRESCALE_WIDTH-1:0] PRESCALE_LAST = PRESCALE_WIDTH'(PRESCALE_MAX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t                    state;
    logic [PRESCALE_WIDTH-1:0] prescaler;
    logic [COUNT_WIDTH-1:0]    count;
    logic [COUNT_WIDTH-1:0]    threshold;
    logic [COUNT_WIDTH-1:0]    step;
    logic                      speedStrobeLow;
    logic                      isTick;
    logic                      isSpeedWrap;

    // A base tick only exists while counting down.
    assign isTick      = (state == RUN) && (prescaler == PRESCALE_LAST);
    assign isSpeedWrap = (COUNT_WIDTH'(step + 4'd1) == threshold);

    always_ff @(posedge SC_STATEMACHINE_GENERAL_CLOCK_50 or posedge SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINE_GENERAL_RESET_InHigh) begin
            state          <= IDLE;
            count          <= '0;
            threshold      <= '0;
            prescaler      <= '0;
            step           <= '0;
            speedStrobeLow <= 1'b1;
        end else begin
            speedStrobeLow <= 1'b1;
            if (!SC_TIMER_GENERAL_clear_InLow) begin
                // Abort wins over everything, including a same-cycle load or tick.
                state     <= IDLE;
                count     <= '0;
                prescaler <= '0;
                step      <= '0;
            end else if (!SC_TIMER_GENERAL_load_InLow) begin
                // Load behaves identically in every state; a concurrent tick is dropped.
                count     <= SC_TIMER_GENERAL_timer_InBUS;
                threshold <= SC_TIMER_GENERAL_speed_InBUS;
                prescaler <= '0;
                step      <= '0;
                state     <= (SC_TIMER_GENERAL_timer_InBUS != 4'd0) ? RUN : EXPIRE;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RUN: begin
                        if (isTick) begin
                            prescaler <= '0;
                            count     <= COUNT_WIDTH'(count - 4'd1);
                            if (count == 4'd1) begin
                                state <= EXPIRE;
                            end
                            if (threshold != 4'd0) begin
                                if (isSpeedWrap) begin
                                    step           <= '0;
                                    speedStrobeLow <= 1'b0;
                                end else begin
                                    step <= COUNT_WIDTH'(step + 4'd1);
                                end
                            end
                        end else begin
                            prescaler <= PRESCALE_WIDTH'(prescaler + 1'b1);
                        end
                    end
                    EXPIRE:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign SC_TIMER_GENERAL_timer_OutLow           = (state != EXPIRE);
    assign SC_TIMER_GENERAL_busy_Out               = (state == RUN);
    assign SC_TIMER_GENERAL_speedComparator_OutLow = speedStrobeLow;
    assign SC_TIMER_GENERAL_count_OutBUS           = count;

endmodule

// File: tb/tb_sc_timer_general.sv
// Directed, table-driven bench for sc_timer_general with a short prescaler.
// Each vector is driven before an edge and checked mid-cycle after it, repeated reps times.
module tb_sc_timer_general;

    localparam int unsigned PM = 4;
    localparam int unsigned PW = 3;

    logic       clk;
    logic       rst;
    logic       loadN;
    logic       clearN;
    logic [3:0] tmr;
    logic [3:0] spd;
    logic       timerLow;
    logic       speedLow;
    logic [3:0] cnt;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    sc_timer_general #(
        .PRESCALE_MAX  (PM),
        .PRESCALE_WIDTH(PW)
    ) dut (
        .SC_STATEMACHINE_GENERAL_CLOCK_50       (clk),
        .SC_STATEMACHINE_GENERAL_RESET_InHigh   (rst),
        .SC_TIMER_GENERAL_load_InLow            (loadN),
        .SC_TIMER_GENERAL_clear_InLow           (clearN),
        .SC_TIMER_GENERAL_timer_InBUS           (tmr),
        .SC_TIMER_GENERAL_speed_InBUS           (spd),
        .SC_TIMER_GENERAL_timer_OutLow          (timerLow),
        .SC_TIMER_GENERAL_speedComparator_OutLow(speedLow),
        .SC_TIMER_GENERAL_count_OutBUS          (cnt),
        .SC_TIMER_GENERAL_busy_Out              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       loadN;
        logic       clearN;
        logic [3:0] tmr;
        logic [3:0] spd;
        int         reps;
        logic       expT;
        logic       expS;
        logic       expBusy;
        logic [3:0] expCnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string nm, input logic ld, input logic cl,
                                input logic [3:0] t, input logic [3:0] s, input int r,
                                input logic eT, input logic eS, input logic eB,
                                input logic [3:0] eC);
        vec_t v;
        v.name = nm; v.loadN = ld; v.clearN = cl; v.tmr = t; v.spd = s; v.reps = r;
        v.expT = eT; v.expS = eS; v.expBusy = eB; v.expCnt = eC;
        vecs.push_back(v);
    endfunction

    task automatic check(input string nm, input int idx, input logic [6:0] exp);
        logic [6:0] got;
        got = {timerLow, speedLow, busy, cnt};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s #%0d: got timer/speed/busy/count=%b want %b", nm, idx, got, exp);
        end
    endtask

    task automatic idleInputs();
        loadN = 1'b1; clearN = 1'b1; tmr = 4'd0; spd = 4'd0;
    endtask

    initial begin
        // Basic expiry: N=3, no speed strobes.
        add("basic", 0, 1, 4'd3, 4'd0, 1, 1, 1, 1, 4'd3);
        add("basic", 1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd3);
        add("basic", 1, 1, 4'd0, 4'd0, 4, 1, 1, 1, 4'd2);
        add("basic", 1, 1, 4'd0, 4'd0, 4, 1, 1, 1, 4'd1);
        add("basic", 1, 1, 4'd0, 4'd0, 1, 0, 1, 0, 4'd0);
        add("basic", 1, 1, 4'd0, 4'd0, 2, 1, 1, 0, 4'd0);
        // Speed strobes every 2nd tick, last one coincides with expiry.
        add("speed", 0, 1, 4'd6, 4'd2, 1, 1, 1, 1, 4'd6);
        add("speed", 1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd6);
        add("speed", 1, 1, 4'd0, 4'd0, 4, 1, 1, 1, 4'd5);
        add("speed", 1, 1, 4'd0, 4'd0, 1, 1, 0, 1, 4'd4);
        add("speed", 1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd4);
        add("speed", 1, 1, 4'd0, 4'd0, 4, 1, 1, 1, 4'd3);
        add("speed", 1, 1, 4'd0, 4'd0, 1, 1, 0, 1, 4'd2);
        add("speed", 1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd2);
        add("speed", 1, 1, 4'd0, 4'd0, 4, 1, 1, 1, 4'd1);
        add("speed", 1, 1, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0);
        add("speed", 1, 1, 4'd0, 4'd0, 2, 1, 1, 0, 4'd0);
        // Threshold 1 strobes on every tick.
        add("thr1",  0, 1, 4'd2, 4'd1, 1, 1, 1, 1, 4'd2);
        add("thr1",  1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd2);
        add("thr1",  1, 1, 4'd0, 4'd0, 1, 1, 0, 1, 4'd1);
        add("thr1",  1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd1);
        add("thr1",  1, 1, 4'd0, 4'd0, 1, 0, 0, 0, 4'd0);
        add("thr1",  1, 1, 4'd0, 4'd0, 1, 1, 1, 0, 4'd0);
        // N=1 boundary.
        add("n1",    0, 1, 4'd1, 4'd0, 1, 1, 1, 1, 4'd1);
        add("n1",    1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd1);
        add("n1",    1, 1, 4'd0, 4'd0, 1, 0, 1, 0, 4'd0);
        add("n1",    1, 1, 4'd0, 4'd0, 1, 1, 1, 0, 4'd0);
        // Zero load, then back-to-back zero load.
        add("zero",  0, 1, 4'd0, 4'd3, 1, 0, 1, 0, 4'd0);
        add("zero",  0, 1, 4'd0, 4'd3, 1, 0, 1, 0, 4'd0);
        add("zero",  1, 1, 4'd0, 4'd0, 3, 1, 1, 0, 4'd0);
        // Restart at edge 6 with N=2.
        add("restart", 0, 1, 4'd5, 4'd0, 1, 1, 1, 1, 4'd5);
        add("restart", 1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd5);
        add("restart", 1, 1, 4'd0, 4'd0, 2, 1, 1, 1, 4'd4);
        add("restart", 0, 1, 4'd2, 4'd0, 1, 1, 1, 1, 4'd2);
        add("restart", 1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd2);
        add("restart", 1, 1, 4'd0, 4'd0, 4, 1, 1, 1, 4'd1);
        add("restart", 1, 1, 4'd0, 4'd0, 1, 0, 1, 0, 4'd0);
        add("restart", 1, 1, 4'd0, 4'd0, 1, 1, 1, 0, 4'd0);
        // Clear together with load at edge 6: clear wins, nothing afterwards.
        add("clrload", 0, 1, 4'd5, 4'd0, 1, 1, 1, 1, 4'd5);
        add("clrload", 1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd5);
        add("clrload", 1, 1, 4'd0, 4'd0, 2, 1, 1, 1, 4'd4);
        add("clrload", 0, 0, 4'd2, 4'd0, 1, 1, 1, 0, 4'd0);
        add("clrload", 1, 1, 4'd0, 4'd0, 25, 1, 1, 0, 4'd0);
        // Clear on a speed tick suppresses that strobe.
        add("clrspd",  0, 1, 4'd2, 4'd1, 1, 1, 1, 1, 4'd2);
        add("clrspd",  1, 1, 4'd0, 4'd0, 3, 1, 1, 1, 4'd2);
        add("clrspd",  1, 0, 4'd0, 4'd0, 1, 1, 1, 0, 4'd0);
        add("clrspd",  1, 1, 4'd0, 4'd0, 10, 1, 1, 0, 4'd0);

        rst = 1'b1;
        idleInputs();
        #2;
        check("reset", 0, 7'b1100000);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                loadN  = vecs[i].loadN;
                clearN = vecs[i].clearN;
                tmr    = vecs[i].tmr;
                spd    = vecs[i].spd;
                @(posedge clk);
                @(negedge clk);
                check(vecs[i].name, i,
                      {vecs[i].expT, vecs[i].expS, vecs[i].expBusy, vecs[i].expCnt});
            end
        end

        // Async reset mid-cycle 7 while counting N=4.
        loadN = 1'b0; tmr = 4'd4; spd = 4'd1;
        @(posedge clk);
        @(negedge clk);
        check("areset_load", 0, 7'b1110100);
        idleInputs();
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("areset_pre", 0, 7'b1110011);
        #1 rst = 1'b1;
        #1 check("areset_now", 0, 7'b1100000);
        @(posedge clk);
        @(negedge clk);
        check("areset_hold", 0, 7'b1100000);
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("areset_after", c, 7'b1100000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
